// File: rtl/coin_feed_scheduler.sv
// coin_feed_scheduler: queues coin sensor pulses and feeds them one at a time
// to vending_machine, then runs the dispenser / change-return handshakes.
module coin_feed_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     five_in,
    input  logic                     ten_in,
    output logic                     five_coin,
    output logic                     ten_coin,
    input  logic                     bottle,
    input  logic                     change,
    output logic                     disp_req,
    input  logic                     disp_done,
    output logic                     chg_req,
    input  logic                     chg_done,
    output logic                     coin_reject,
    output logic                     fault,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_CHECK,
        S_DISPENSE,
        S_CHANGE,
        S_FAULT
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TW-1:0]    tmo_cnt;
    logic             chg_lat;

    logic [CW-1:0]    free_c;
    logic             push_a_c;
    logic             push_b_c;
    logic             bit_a_c;
    logic             reject_c;
    logic             pop_c;
    logic             head_c;
    logic             have_coin_c;
    logic             tmo_hit_c;

    // Admission: decide which sensor pulses fit in the FIFO (five before ten).
    always_comb begin
        push_a_c = 1'b0;
        push_b_c = 1'b0;
        bit_a_c  = 1'b0;
        reject_c = 1'b0;
        free_c   = CW'(DEPTH) - fifo_count;
        if (state == S_FAULT) begin
            reject_c = five_in | ten_in;
        end else if (five_in && ten_in) begin
            if (free_c >= CW'(2)) begin
                push_a_c = 1'b1;
                push_b_c = 1'b1;
            end else if (free_c == CW'(1)) begin
                push_a_c = 1'b1;
                reject_c = 1'b1;
            end else begin
                reject_c = 1'b1;
            end
        end else if (five_in || ten_in) begin
            if (free_c != CW'(0)) begin
                push_a_c = 1'b1;
                bit_a_c  = ten_in;
            end else begin
                reject_c = 1'b1;
            end
        end
    end

    assign have_coin_c = (fifo_count != CW'(0));
    assign head_c      = mem[rd_ptr];
    assign tmo_hit_c   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign pop_c       = (state_nxt == S_FEED);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a done seen on the expiry cycle takes priority over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (have_coin_c) state_nxt = S_FEED;
            end
            S_FEED: begin
                state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (bottle)           state_nxt = S_DISPENSE;
                else if (change)      state_nxt = S_CHANGE;
                else if (have_coin_c) state_nxt = S_FEED;
                else                  state_nxt = S_IDLE;
            end
            S_DISPENSE: begin
                if (disp_done) begin
                    if (chg_lat)          state_nxt = S_CHANGE;
                    else if (have_coin_c) state_nxt = S_FEED;
                    else                  state_nxt = S_IDLE;
                end else if (tmo_hit_c) begin
                    state_nxt = S_FAULT;
                end
            end
            S_CHANGE: begin
                if (chg_done) begin
                    if (have_coin_c) state_nxt = S_FEED;
                    else             state_nxt = S_IDLE;
                end else if (tmo_hit_c) begin
                    state_nxt = S_FAULT;
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Coin FIFO storage and occupancy; pop happens on every entry to FEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_a_c) mem[wr_ptr] <= bit_a_c;
            if (push_b_c) mem[wr_ptr + AW'(1)] <= 1'b1;
            wr_ptr     <= wr_ptr + AW'(push_a_c) + AW'(push_b_c);
            rd_ptr     <= rd_ptr + AW'(pop_c);
            fifo_count <= fifo_count + CW'(push_a_c) + CW'(push_b_c) - CW'(pop_c);
        end
    end

    // Handshake timeout counter, cleared on each entry to DISPENSE or CHANGE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state_nxt != state) &&
                     ((state_nxt == S_DISPENSE) || (state_nxt == S_CHANGE))) begin
            tmo_cnt <= '0;
        end else if ((state == S_DISPENSE) || (state == S_CHANGE)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Remember the change request seen in CHECK for use after dispensing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_lat <= 1'b0;
        end else if (state == S_CHECK) begin
            chg_lat <= change;
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            five_coin   <= 1'b0;
            ten_coin    <= 1'b0;
            disp_req    <= 1'b0;
            chg_req     <= 1'b0;
            coin_reject <= 1'b0;
            fault       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            five_coin   <= pop_c & ~head_c;
            ten_coin    <= pop_c & head_c;
            disp_req    <= (state_nxt == S_DISPENSE);
            chg_req     <= (state_nxt == S_CHANGE);
            coin_reject <= reject_c;
            fault       <= fault | (state_nxt == S_FAULT);
            busy        <= (state_nxt != S_IDLE);
        end
    end

endmodule
